alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised successor of the 8-bit combinational ALU. It has registered outputs and a valid/ready handshake on both sides, plus a multi-cycle signed shift-add multiplier in place of the array multiplier. Single-cycle ops stream at one result per cycle. MUL holds the block busy for WIDTH iterations. It sits between the datapath issue stage and writeback.

Parameters:
WIDTH, 8, operand/result width; must be >= 4
OPW, 4, opcode width (fixed encoding below)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  operation offered
in_ready  out  1  block accepts operation this cycle
a  in  WIDTH  operand A (two's complement for signed ops)
b  in  WIDTH  operand B
op  in  OPW  opcode
out_valid  out  1  result registers hold a valid result
out_ready  in  1  consumer takes result this cycle
result  out  WIDTH  logic/shift/arith result; 0 for MUL
product  out  2*WIDTH  signed product; 0 for non-MUL
of  out  1  signed overflow flag
zero  out  1  zero flag
slt  out  1  signed a<b, meaningful for SUB only
busy  out  1  multiplier iterating

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset. During reset all outputs are 0 except in_ready, which is 1 after release. State is IDLE.
- Opcodes:
  - 0000 NOT a
  - 0001 AND
  - 0010 OR
  - 0011 SRL1
  - 0100 SLL1
  - 0101 SRA1 (sign fill)
  - 0110 SLA1 = {a[W-1], a[W-3:0], 0}
  - 0111 ROR1
  - 1000 ROL1
  - 1001 ADD
  - 1010 SUB (a + ~b + 1)
  - 1011 MUL (signed)
  - other: result 0, all flags 0
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - in_ready = (state != MUL_RUN) && (!out_valid || out_ready).
  - Outputs and flags are held stable while out_valid && !out_ready.
- Latency:
  - Non-MUL: out_valid on the cycle after acceptance. Back-to-back throughput is 1/cycle when out_ready=1.
  - MUL: out_valid exactly WIDTH+1 cycles after acceptance.
- FSM states: IDLE, MUL_RUN.
  - IDLE -> MUL_RUN on accepted MUL. This loads |a|, |b| as WIDTH+1-bit magnitudes, clears the accumulator, sets counter=WIDTH, busy=1, and drops out_valid.
  - MUL_RUN: each cycle, if multiplier LSB=1 add shifted multiplicand; shift; counter--.
  - At counter==1 the final iteration writes product (negated if a[W-1]^b[W-1]), sets out_valid=1, busy=0, and returns to IDLE.
- Flags:
  - ADD/SUB: of = signed overflow (operand MSBs equal and result MSB differs; for SUB compare against ~b). slt = result[W-1] ^ of.
  - MUL: of=1 when the product does not fit in signed WIDTH bits (upper WIDTH+1 bits not all equal).
  - zero = (result==0) for non-MUL, (product==0) for MUL. It is independent of of.
  - All other ops: of=0, slt=0.
- Boundaries:
  - Most-negative operands are handled by the WIDTH+1 magnitude.
  - in_valid while busy is ignored with no side effects.
  - op/a/b changing while not accepted have no effect.
  - rst_n low mid-MUL aborts the multiply; no stale product appears after reset.

Optional Feature:
- Macro: ALU_SEQ_MUL_EARLY_TERM_EN.
- Defined: MUL_RUN finishes as soon as the remaining multiplier bits are all zero, minimum 1 iteration. Latency is 2..WIDTH+1 cycles; results are identical.
- Undefined: fixed WIDTH+1 latency.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_NOT..OP_MUL), state typedef {IDLE, MUL_RUN}, and a flag-struct typedef.
- Sub-module alu_seq_mul: sequential magnitude shift-add core with start/done, sign fix-up, and the early-term macro.
- Top keeps the single-cycle ops, flags, FSM and handshake.

Test Plan (all with WIDTH=8):
- ADD a=0x7F b=0x01 -> result 0x80, of=1, zero=0; out_valid 1 cycle after accept. ADD 0xFF+0x01 -> 0x00, zero=1, of=0.
- SUB a=0x03 b=0x05 -> 0xFE, slt=1, of=0. SUB 0x80-0x01 -> 0x7F, of=1, slt=1.
- Shifts a=0x90: SRA -> 0xC8; SLA -> 0xA0; ROL a=0x81 -> 0x03; SRL -> 0x48.
- MUL -3*5 -> product 0xFFF1, of=0, after 9 cycles with busy high 8 cycles. MUL 0x80*0x80 -> 0x4000, of=1. MUL 0*0x55 -> zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an ADD -> outputs stable, in_ready=0. Then stream 4 ops with out_ready=1 -> 4 results on 4 consecutive cycles.
- Reset mid-MUL: drop rst_n at iteration 4 -> all outputs 0 immediately. After release in_ready=1, and a new ADD 2+2 -> result 0x04.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq block.
//   - Opcode encodings (OP_NOT .. OP_MUL). The encoding is fixed at 4 bits.
//   - state_t : top-level FSM states (IDLE, MUL_RUN).
//   - flags_t : registered flag bundle (of, zero, slt).
package alu_seq_pkg;

  localparam int OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_NOT = 4'b0000;
  localparam logic [OP_BITS-1:0] OP_AND = 4'b0001;
  localparam logic [OP_BITS-1:0] OP_OR  = 4'b0010;
  localparam logic [OP_BITS-1:0] OP_SRL = 4'b0011;
  localparam logic [OP_BITS-1:0] OP_SLL = 4'b0100;
  localparam logic [OP_BITS-1:0] OP_SRA = 4'b0101;
  localparam logic [OP_BITS-1:0] OP_SLA = 4'b0110;
  localparam logic [OP_BITS-1:0] OP_ROR = 4'b0111;
  localparam logic [OP_BITS-1:0] OP_ROL = 4'b1000;
  localparam logic [OP_BITS-1:0] OP_ADD = 4'b1001;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'b1010;
  localparam logic [OP_BITS-1:0] OP_MUL = 4'b1011;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

  typedef struct packed {
    logic of;
    logic zero;
    logic slt;
  } flags_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Sequential signed multiplier core for alu_seq.
// Works on WIDTH+1-bit magnitudes so the most-negative operand is exact,
// runs one shift-add iteration per cycle and applies the sign at the end.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin iterating (ignored while running)
//   a, b       : signed WIDTH-bit operands, sampled on start
//   done       : high during the cycle whose clock edge completes the multiply
//   product    : signed 2*WIDTH-bit product, valid while done is high
//
// Build option: ALU_SEQ_MUL_EARLY_TERM_EN ends the run as soon as the
// remaining multiplier bits are all zero (at least one iteration).
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               running;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH:0]     mplier;
  logic               neg;

  logic [WIDTH:0]     mag_a;
  logic [WIDTH:0]     mag_b;
  logic [2*WIDTH-1:0] acc_next;
  logic               last;

  // |x| as WIDTH+1 bits: -2^(WIDTH-1) becomes 2^(WIDTH-1) without wrapping.
  assign mag_a = a[WIDTH-1] ? ({1'b0, ~a} + (WIDTH+1)'(1)) : {1'b0, a};
  assign mag_b = b[WIDTH-1] ? ({1'b0, ~b} + (WIDTH+1)'(1)) : {1'b0, b};

  assign acc_next = mplier[0] ? (acc + mcand) : acc;

`ifdef ALU_SEQ_MUL_EARLY_TERM_EN
  // Bits still to be consumed after this iteration are mplier[WIDTH:1].
  assign last = running && ((count == CW'(1)) || (mplier[WIDTH:1] == '0));
`else
  assign last = running && (count == CW'(1));
`endif

  assign done    = last;
  assign product = neg ? (~acc_next + (2*WIDTH)'(1)) : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
    end else if (start && !running) begin
      running <= 1'b1;
      count   <= CW'(WIDTH);
      acc     <= '0;
      mcand   <= {{(WIDTH-1){1'b0}}, mag_a};
      mplier  <= mag_b;
      neg     <= a[WIDTH-1] ^ b[WIDTH-1];
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
      if (last) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and a
// multi-cycle signed multiplier (alu_seq_mul).
//
// Handshake: an operation transfers in when in_valid && in_ready, a result
// transfers out when out_valid && out_ready. in_ready is low while the
// multiplier runs and while an untaken result is held; held results and
// flags stay stable until taken.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake (a, b, op)
//   out_valid/out_ready : result handshake
//   result              : single-cycle op result (0 for MUL)
//   product             : signed 2*WIDTH product (0 for non-MUL)
//   of, zero, slt       : flags
//   busy                : multiplier iterating (FSM in MUL_RUN)
//
// Build option: ALU_SEQ_MUL_EARLY_TERM_EN (see alu_seq_mul).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [OPW-1:0]     op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic               of,
  output logic               zero,
  output logic               slt,
  output logic               busy
);

  state_t             state;
  flags_t             flags_q;
  logic               rst_done;   // keeps in_ready low while in reset
  logic               accept;
  logic               mul_start;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flg;
  logic               legal;

  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     prod_hi;
  flags_t             mul_flg;

  assign in_ready  = rst_done && (state != MUL_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op == OP_MUL);

  assign busy   = (state == MUL_RUN);
  assign of     = flags_q.of;
  assign zero   = flags_q.zero;
  assign slt    = flags_q.slt;

  assign sum  = a + b;
  assign diff = a + ~b + WIDTH'(1);

  // Single-cycle datapath. Unused opcodes (and MUL here) leave all flags 0.
  always_comb begin
    alu_res = '0;
    alu_flg = '0;
    legal   = 1'b1;
    case (op)
      OP_NOT: alu_res = ~a;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_SRL: alu_res = {1'b0, a[WIDTH-1:1]};
      OP_SLL: alu_res = {a[WIDTH-2:0], 1'b0};
      OP_SRA: alu_res = {a[WIDTH-1], a[WIDTH-1:1]};
      // Arithmetic left shift keeps the sign bit and drops bit WIDTH-2.
      OP_SLA: alu_res = {a[WIDTH-1], a[WIDTH-3:0], 1'b0};
      OP_ROR: alu_res = {a[0], a[WIDTH-1:1]};
      OP_ROL: alu_res = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ADD: begin
        alu_res    = sum;
        alu_flg.of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        alu_flg.slt = sum[WIDTH-1] ^ alu_flg.of;
      end
      OP_SUB: begin
        alu_res    = diff;
        alu_flg.of = (a[WIDTH-1] == ~b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        alu_flg.slt = diff[WIDTH-1] ^ alu_flg.of;
      end
      default: legal = 1'b0;
    endcase
    alu_flg.zero = legal && (alu_res == '0);
  end

  // Product fits in signed WIDTH bits only if its top WIDTH+1 bits agree.
  assign prod_hi = mul_prod[2*WIDTH-1:WIDTH-1];
  always_comb begin
    mul_flg      = '0;
    mul_flg.of   = !((&prod_hi) || (prod_hi == '0));
    mul_flg.zero = (mul_prod == '0);
  end

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rst_done  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      product   <= '0;
      flags_q   <= '0;
    end else begin
      rst_done <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              state     <= MUL_RUN;
              out_valid <= 1'b0;
              result    <= '0;
              product   <= '0;
              flags_q   <= '0;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_res;
              product   <= '0;
              flags_q   <= alu_flg;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL_RUN: begin
          if (mul_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            result    <= '0;
            product   <= mul_prod;
            flags_q   <= mul_flg;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8).
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  result;
  logic [15:0] product;
  logic        of;
  logic        zero;
  logic        slt;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  alu_seq #(.WIDTH(8), .OPW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .product   (product),
    .of        (of),
    .zero      (zero),
    .slt       (slt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Driver: offer one op at a negedge, hold until accepted at a posedge.
  task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL send_accept: in_ready got %b expected 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Driver: issue a MUL and count negedges until out_valid (bounded).
  task automatic run_mul(input logic [7:0] x, input logic [7:0] y,
                         output int lat, output int busy_cnt);
    send(OP_MUL, x, y);
    lat = 0;
    busy_cnt = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    #2;
    compared++;
    if ({in_ready, out_valid, result, product, of, zero, slt, busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b res=%h prod=%h of=%b z=%b slt=%b busy=%b expected all 0",
               in_ready, out_valid, result, product, of, zero, slt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: got rdy=%b ov=%b expected rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add;
    send(OP_ADD, 8'h7F, 8'h01);
    @(negedge clk);
    compared++;
    if ({out_valid, result, of, zero, slt, product} !== {1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 16'h0000}) begin
      mismatched++;
      $display("FAIL add_7f_01: got ov=%b res=%h of=%b z=%b slt=%b prod=%h expected ov=1 res=80 of=1 z=0 slt=0 prod=0000",
               out_valid, result, of, zero, slt, product);
    end
    send(OP_ADD, 8'hFF, 8'h01);
    @(negedge clk);
    compared++;
    if ({out_valid, result, of, zero} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL add_ff_01: got ov=%b res=%h of=%b z=%b expected ov=1 res=00 of=0 z=1",
               out_valid, result, of, zero);
    end
  endtask

  task automatic test_sub;
    send(OP_SUB, 8'h03, 8'h05);
    @(negedge clk);
    compared++;
    if ({result, slt, of, zero} !== {8'hFE, 1'b1, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL sub_03_05: got res=%h slt=%b of=%b z=%b expected res=fe slt=1 of=0 z=0",
               result, slt, of, zero);
    end
    send(OP_SUB, 8'h80, 8'h01);
    @(negedge clk);
    compared++;
    if ({result, slt, of} !== {8'h7F, 1'b1, 1'b1}) begin
      mismatched++;
      $display("FAIL sub_80_01: got res=%h slt=%b of=%b expected res=7f slt=1 of=1", result, slt, of);
    end
  endtask

  task automatic test_logic_shift;
    logic [3:0] t_op[10];
    logic [7:0] t_a[10];
    logic [7:0] t_b[10];
    logic [7:0] t_exp[10];
    t_op[0] = OP_NOT; t_a[0] = 8'h0F; t_b[0] = 8'h00; t_exp[0] = 8'hF0;
    t_op[1] = OP_AND; t_a[1] = 8'hF0; t_b[1] = 8'h3C; t_exp[1] = 8'h30;
    t_op[2] = OP_OR;  t_a[2] = 8'h0F; t_b[2] = 8'h30; t_exp[2] = 8'h3F;
    t_op[3] = OP_SRL; t_a[3] = 8'h90; t_b[3] = 8'h00; t_exp[3] = 8'h48;
    t_op[4] = OP_SLL; t_a[4] = 8'h90; t_b[4] = 8'h00; t_exp[4] = 8'h20;
    t_op[5] = OP_SRA; t_a[5] = 8'h90; t_b[5] = 8'h00; t_exp[5] = 8'hC8;
    t_op[6] = OP_SLA; t_a[6] = 8'h90; t_b[6] = 8'h00; t_exp[6] = 8'hA0;
    t_op[7] = OP_ROR; t_a[7] = 8'h81; t_b[7] = 8'h00; t_exp[7] = 8'hC0;
    t_op[8] = OP_ROL; t_a[8] = 8'h81; t_b[8] = 8'h00; t_exp[8] = 8'h03;
    t_op[9] = 4'hC;   t_a[9] = 8'hFF; t_b[9] = 8'h11; t_exp[9] = 8'h00;
    for (int i = 0; i < 10; i++) begin
      send(t_op[i], t_a[i], t_b[i]);
      @(negedge clk);
      compared++;
      // No vector here yields zero from a legal op; illegal op keeps zero=0.
      if ({out_valid, result, of, zero, slt} !== {1'b1, t_exp[i], 3'b000}) begin
        mismatched++;
        $display("FAIL op_%h_a%h: got ov=%b res=%h of=%b z=%b slt=%b expected ov=1 res=%h flags=000",
                 t_op[i], t_a[i], out_valid, result, of, zero, slt, t_exp[i]);
      end
    end
  endtask

  task automatic test_mul;
    int lat;
    int bc;
    run_mul(8'hFD, 8'h05, lat, bc);
    compared++;
    if ({out_valid, product, result, of, zero} !== {1'b1, 16'hFFF1, 8'h00, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL mul_m3_5: got ov=%b prod=%h res=%h of=%b z=%b expected ov=1 prod=fff1 res=00 of=0 z=0",
               out_valid, product, result, of, zero);
    end
    compared++;
`ifdef ALU_SEQ_MUL_EARLY_TERM_EN
    if (lat < 2 || lat > 9 || bc != lat - 1) begin
`else
    if (lat != 9 || bc != 8) begin
`endif
      mismatched++;
      $display("FAIL mul_latency: got lat=%0d busy_cycles=%0d expected lat=9 busy_cycles=8", lat, bc);
    end
    run_mul(8'h80, 8'h80, lat, bc);
    compared++;
    if ({out_valid, product, of, zero} !== {1'b1, 16'h4000, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL mul_80_80: got ov=%b prod=%h of=%b z=%b expected ov=1 prod=4000 of=1 z=0",
               out_valid, product, of, zero);
    end
    run_mul(8'h00, 8'h55, lat, bc);
    compared++;
    if ({out_valid, product, of, zero} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL mul_0_55: got ov=%b prod=%h of=%b z=%b expected ov=1 prod=0000 of=0 z=1",
               out_valid, product, of, zero);
    end
  endtask

  // An op offered while the multiplier runs must be ignored.
  task automatic test_busy_ignore;
    int n;
    send(OP_MUL, 8'h02, 8'h03);
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h01;
    #1;
    compared++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_in_ready: got rdy=%b busy=%b expected rdy=0 busy=1", in_ready, busy);
    end
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if ({out_valid, product, result} !== {1'b1, 16'h0006, 8'h00}) begin
      mismatched++;
      $display("FAIL busy_mul_2_3: got ov=%b prod=%h res=%h expected ov=1 prod=0006 res=00",
               out_valid, product, result);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_no_extra: got ov=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] s_op[4];
    logic [7:0] s_a[4];
    logic [7:0] s_b[4];
    logic [7:0] s_exp[4];
    s_op[0] = OP_ADD; s_a[0] = 8'h01; s_b[0] = 8'h02; s_exp[0] = 8'h03;
    s_op[1] = OP_SUB; s_a[1] = 8'h09; s_b[1] = 8'h04; s_exp[1] = 8'h05;
    s_op[2] = OP_AND; s_a[2] = 8'hF0; s_b[2] = 8'h3C; s_exp[2] = 8'h30;
    s_op[3] = OP_OR;  s_a[3] = 8'h0F; s_b[3] = 8'h30; s_exp[3] = 8'h3F;
    out_ready = 1'b0;
    send(OP_ADD, 8'h10, 8'h20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compared++;
      if ({out_valid, result, in_ready} !== {1'b1, 8'h30, 1'b0}) begin
        mismatched++;
        $display("FAIL hold_cycle%0d: got ov=%b res=%h rdy=%b expected ov=1 res=30 rdy=0",
                 i, out_valid, result, in_ready);
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        compared++;
        if ({out_valid, result} !== {1'b1, s_exp[i-1]}) begin
          mismatched++;
          $display("FAIL stream%0d: got ov=%b res=%h expected ov=1 res=%h",
                   i - 1, out_valid, result, s_exp[i-1]);
        end
      end
      if (i < 4) begin
        out_ready = 1'b1;
        in_valid = 1'b1; op = s_op[i]; a = s_a[i]; b = s_b[i];
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL stream_ready%0d: got %b expected 1", i, in_ready);
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_mul;
    send(OP_MUL, 8'h7F, 8'h7F);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({in_ready, out_valid, result, product, of, zero, slt, busy} !== '0) begin
      mismatched++;
      $display("FAIL reset_mid_mul: got rdy=%b ov=%b res=%h prod=%h of=%b z=%b slt=%b busy=%b expected all 0",
               in_ready, out_valid, result, product, of, zero, slt, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    compared++;
    if ({in_ready, out_valid, busy, product} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      mismatched++;
      $display("FAIL after_reset: got rdy=%b ov=%b busy=%b prod=%h expected rdy=1 ov=0 busy=0 prod=0000",
               in_ready, out_valid, busy, product);
    end
    send(OP_ADD, 8'h02, 8'h02);
    @(negedge clk);
    compared++;
    if ({out_valid, result, product} !== {1'b1, 8'h04, 16'h0000}) begin
      mismatched++;
      $display("FAIL add_after_reset: got ov=%b res=%h prod=%h expected ov=1 res=04 prod=0000",
               out_valid, result, product);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic_shift();
    test_mul();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
